serial_add_sequencer: RTL and testbench

- Word-level controller wrapped around a bit-serial full adder: one carry flip-flop, with sum and carry built from logic operations only.
- Accepts a pair of W-bit operands over a valid/ready handshake and feeds them LSB-first through the adder, one bit per clock.
- Collects the sum bits back into a W-bit word and presents the result and carry-out over a second valid/ready handshake.
- Sits between a parallel producer and consumer that need addition without a W-bit carry chain.

---
 rtl/serial_add_sequencer.sv | 117 +++++++++++
 tb/tb_serial_add_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: accepts a W-bit operand pair, adds it LSB-first
// through a single carry flop, and returns sum/carry-out. Optional subtract mode via SERIAL_ADD_SUB_EN.
module serial_add_sequencer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    // state | meaning
    // IDLE  | waiting for an operand pair, in_ready high
    // RUN   | shifting one bit per cycle through the adder
    // DONE  | result presented, out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  sa, sb, acc;

    logic          accept, last;
    logic          s, carry_d;
    logic [W-1:0]  acc_shift;
    logic [W-1:0]  b_load;
    logic          cin_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                last = (cnt == CW'(W - 1));
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        s       = sa[0] ^ sb[0] ^ carry;
        carry_d = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        acc_shift        = acc >> 1;
        acc_shift[W-1]   = s;
    end

    // Subtraction is a + ~b + ~borrow, so only the load path changes.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load   = in_sub ? ~in_b   : in_b;
    assign cin_load = in_sub ? ~in_cin : in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (accept) begin
            sa    <= in_a;
            sb    <= b_load;
            carry <= cin_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= carry_d;
            acc   <= acc_shift;
            if (last) begin
                out_sum  <= acc_shift;
                out_cout <= carry_d;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (W=8): vector table plus
// directed back-pressure, mid-run reset and back-to-back sequences.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Called at the negedge after the accepting edge; lat counts edges to out_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] sum, output logic cout, output int lat);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        sum  = out_sum;
        cout = out_cout;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sum;
        logic         cout;
        int           lat;
        int           t0, t1;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        in_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout, lat);
            chk($sformatf("vec%0d_sum", i),  32'(sum),  32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_lat", i),  32'(lat),  32'(W));
        end

        // Back-pressure: result held 5 cycles while a new operand waits.
        out_ready = 1'b0;
        in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b0; in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0;
        wait_valid(lat);
        chk("hold_lat", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_sum",   32'(out_sum),   32'h96);
            chk("hold_out_cout",  32'(out_cout),  32'd0);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release_in_ready",  32'(in_ready),  32'd1);
        chk("hold_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("hold_next_sum", 32'(out_sum), 32'h02);
        @(posedge clk);
        @(negedge clk);

        // Reset 3 cycles into RUN.
        in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b1; in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rel_in_ready",  32'(in_ready),  32'd1);
        chk("abort_rel_out_valid", 32'(out_valid), 32'd0);
        chk("abort_rel_out_sum",   32'(out_sum),   32'd0);
        run_op(8'h01, 8'h02, 1'b0, sum, cout, lat);
        chk("abort_next_sum",  32'(sum),  32'h03);
        chk("abort_next_cout", 32'(cout), 32'd0);
        chk("abort_next_lat",  32'(lat),  32'(W));

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0; in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        in_a = 8'h7F; in_b = 8'h01;
        wait_valid(lat);
        chk("b2b_0_sum",  32'(out_sum),  32'h30);
        chk("b2b_0_cout", 32'(out_cout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t1 = cyc;
        in_valid = 1'b0;
        chk("b2b_period", 32'(t1 - t0), 32'(W + 2));
        chk("b2b_1_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("b2b_1_sum",  32'(out_sum),  32'h80);
        chk("b2b_1_cout", 32'(out_cout), 32'd0);
        @(posedge clk);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        in_sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, sum, cout, lat);
        chk("sub0_sum",  32'(sum),  32'h0F);
        chk("sub0_cout", 32'(cout), 32'd1);
        run_op(8'h00, 8'h01, 1'b0, sum, cout, lat);
        chk("sub1_sum",  32'(sum),  32'hFF);
        chk("sub1_cout", 32'(cout), 32'd0);
        in_sub = 1'b0;
        run_op(8'h10, 8'h01, 1'b0, sum, cout, lat);
        chk("sub_off_sum", 32'(sum), 32'h11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
